// File: rtl/histogram_cdf_lut.sv
// Histogram-equalization LUT builder: reads the frame histogram over BRAM port B,
// accumulates the CDF, scales it to the output gray range and writes one LUT entry per level.
module histogram_cdf_lut #(
  parameter int NB_BRAM_DLY  = 2,
  parameter int NB_IMG_HORI  = 960,
  parameter int NB_IMG_VERT  = 640,
  parameter int NB_START_DLY = 8,
  parameter int WD_BRAM_ADR  = 8,
  parameter int WD_BRAM_DAT  = 32,
  parameter int WD_IMG_DATA  = 8,
  parameter int WD_FRAC      = 24,
  parameter int WD_ERR_INFO  = 4
) (
  input  logic                   i_sys_clk,
  input  logic                   i_sys_rst,
  input  logic                   s_img_gray_c_fsync,
  output logic                   m_bram_hist_enb,
  output logic [WD_BRAM_ADR-1:0] m_bram_hist_addrb,
  input  logic [WD_BRAM_DAT-1:0] m_bram_hist_doutb,
  output logic                   m_lut_wr_en,
  output logic [WD_IMG_DATA-1:0] m_lut_wr_addr,
  output logic [WD_IMG_DATA-1:0] m_lut_wr_data,
  output logic                   m_lut_busy,
  output logic                   m_lut_done,
  output logic [WD_ERR_INFO-1:0] m_err_lut_info1
);

  localparam int unsigned L  = 2 ** WD_IMG_DATA;
  localparam int unsigned WC = WD_BRAM_DAT + WD_IMG_DATA;
  // Extra WD_IMG_DATA bits of headroom so the rounded product can never wrap.
  localparam int unsigned WP = WC + WD_FRAC + WD_IMG_DATA;
  localparam logic [WC-1:0] N_PIX = WC'(NB_IMG_HORI * NB_IMG_VERT);
  localparam logic [WP-1:0] K =
    WP'(((64'(L) - 64'd1) << WD_FRAC) / 64'(NB_IMG_HORI * NB_IMG_VERT));
  localparam logic [WP-1:0] RND = WP'(1) << (WD_FRAC - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                   state;
  logic                     fsync_q;
  logic                     fall;
  logic [15:0]              cnt;
  logic [WD_IMG_DATA-1:0]   rd_lvl;
  logic [NB_BRAM_DLY-1:0]   vld_sr;
  logic                     c_vld;
  logic [WC-1:0]            cdf;
  logic [WD_IMG_DATA-1:0]   wr_idx;
  logic [2:0]               err;
  logic [WP-1:0]            prod;
  logic [WP-1:0]            scaled;
  logic                     sat;
  logic [WD_IMG_DATA-1:0]   lvl;

  assign fall              = fsync_q & ~s_img_gray_c_fsync;
  assign m_bram_hist_addrb = WD_BRAM_ADR'(rd_lvl);
  assign m_err_lut_info1   = WD_ERR_INFO'(err);

  always_comb begin
    prod   = WP'(cdf) * K + RND;
    scaled = prod >> WD_FRAC;
    sat    = scaled > WP'(L - 1);
    lvl    = sat ? '1 : scaled[WD_IMG_DATA-1:0];
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state           <= S_IDLE;
      fsync_q         <= 1'b0;
      cnt             <= '0;
      rd_lvl          <= '0;
      vld_sr          <= '0;
      c_vld           <= 1'b0;
      cdf             <= '0;
      wr_idx          <= '0;
      err             <= '0;
      m_bram_hist_enb <= 1'b0;
      m_lut_wr_en     <= 1'b0;
      m_lut_wr_addr   <= '0;
      m_lut_wr_data   <= '0;
      m_lut_busy      <= 1'b0;
      m_lut_done      <= 1'b0;
    end else begin
      fsync_q <= s_img_gray_c_fsync;

      // Read-valid follows the BRAM latency; C accumulates, M/W scales and writes.
      vld_sr <= (vld_sr << 1) | NB_BRAM_DLY'(m_bram_hist_enb);
      c_vld  <= vld_sr[NB_BRAM_DLY-1];
      if (vld_sr[NB_BRAM_DLY-1]) cdf <= cdf + WC'(m_bram_hist_doutb);

      m_lut_wr_en <= c_vld;
      if (c_vld) begin
        m_lut_wr_addr <= wr_idx;
        m_lut_wr_data <= lvl;
        wr_idx        <= wr_idx + WD_IMG_DATA'(1);
        if (sat) err[2] <= 1'b1;
      end

      m_lut_done <= 1'b0;
      if (fall && state != S_IDLE) err[1] <= 1'b1;

      case (state)
        S_IDLE: begin
          if (fall) begin
            state      <= S_WAIT;
            m_lut_busy <= 1'b1;
            cnt        <= '0;
            cdf        <= '0;
            wr_idx     <= '0;
            err[0]     <= 1'b0;
            err[2]     <= 1'b0;
          end
        end
        S_WAIT: begin
          if (cnt == 16'(NB_START_DLY - 1)) begin
            state           <= S_READ;
            m_bram_hist_enb <= 1'b1;
            rd_lvl          <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_READ: begin
          if (rd_lvl == WD_IMG_DATA'(L - 1)) begin
            state           <= S_DRAIN;
            m_bram_hist_enb <= 1'b0;
            cnt             <= '0;
          end else begin
            rd_lvl <= rd_lvl + WD_IMG_DATA'(1);
          end
        end
        S_DRAIN: begin
          if (cnt == 16'(NB_BRAM_DLY + 1)) begin
            state      <= S_DONE;
            m_lut_done <= 1'b1;
            m_lut_busy <= 1'b0;
            err[0]     <= (cdf != N_PIX);
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_histogram_cdf_lut.sv
// Directed bench for histogram_cdf_lut: three instances (BRAM latency 2, 1, 4) share one
// histogram model and frame stimulus; per-instance monitors log writes, offsets and done pulses.
module tb_histogram_cdf_lut;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fsync = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] hist [256];

  logic        enb_a     [3];
  logic [7:0]  addrb_a   [3];
  logic [31:0] doutb_a   [3];
  logic        wr_en_a   [3];
  logic [7:0]  wr_addr_a [3];
  logic [7:0]  wr_data_a [3];
  logic        busy_a    [3];
  logic        done_a    [3];
  logic [3:0]  err_a     [3];

  int a_cyc    [3];
  int wr_cnt   [3];
  int wr_tot   [3];
  int done_cnt [3];
  int done_cyc [3];
  int offs_bad [3];
  int seq_bad  [3];
  int bsy_bad  [3];
  logic [7:0] lut [3][256];

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int D = (g == 0) ? 2 : (g == 1) ? 1 : 4;
    logic [31:0] pipe [4];

    histogram_cdf_lut #(.NB_BRAM_DLY(D)) dut (
      .i_sys_clk          (clk),
      .i_sys_rst          (rst),
      .s_img_gray_c_fsync (fsync),
      .m_bram_hist_enb    (enb_a[g]),
      .m_bram_hist_addrb  (addrb_a[g]),
      .m_bram_hist_doutb  (doutb_a[g]),
      .m_lut_wr_en        (wr_en_a[g]),
      .m_lut_wr_addr      (wr_addr_a[g]),
      .m_lut_wr_data      (wr_data_a[g]),
      .m_lut_busy         (busy_a[g]),
      .m_lut_done         (done_a[g]),
      .m_err_lut_info1    (err_a[g])
    );

    always @(posedge clk) begin
      pipe[0] <= hist[addrb_a[g]];
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
    assign doutb_a[g] = pipe[D-1];

    initial begin
      wr_cnt[g] = 0; wr_tot[g] = 0; done_cnt[g] = 0; done_cyc[g] = 0;
      offs_bad[g] = 0; seq_bad[g] = 0; bsy_bad[g] = 0; a_cyc[g] = 0;
    end

    always @(negedge clk) begin
      if (enb_a[g] && addrb_a[g] == 8'd0) begin
        a_cyc[g]  = cyc;
        wr_cnt[g] = 0;
      end
      if (wr_en_a[g]) begin
        if (cyc != a_cyc[g] + int'(wr_addr_a[g]) + D + 2) offs_bad[g]++;
        if (int'(wr_addr_a[g]) != wr_cnt[g]) seq_bad[g]++;
        lut[g][wr_addr_a[g]] = wr_data_a[g];
        wr_cnt[g]++;
        wr_tot[g]++;
      end
      if (done_a[g]) begin
        done_cnt[g]++;
        done_cyc[g] = cyc;
        if (busy_a[g]) bsy_bad[g]++;
      end
    end
  end

  int n_assert = 0;
  int n_fail   = 0;
  int fall_cyc;
  int d0 [3];
  int t0 [3];
  int n;
  logic [7:0] ok8;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
    #1;
  endtask

  // One frame-end edge, optional second edge 50 cycles in, then wait for all three builds.
  task automatic build(input string name, input bit extra_fall);
    for (int g = 0; g < 3; g++) d0[g] = done_cnt[g];
    tick(1);
    fsync    = 1'b0;
    fall_cyc = cyc;
    tick(20);
    chk({name, "_busy"}, busy_a[0], 1);
    if (extra_fall) begin
      tick(25);
      fsync = 1'b1;
      tick(5);
      fsync = 1'b0;
    end
    n = 0;
    while (!(done_cnt[0] > d0[0] && done_cnt[1] > d0[1] && done_cnt[2] > d0[2]) && n < 600) begin
      tick(1);
      n++;
    end
    chk({name, "_done_in_time"}, (n < 600), 1);
    tick(3);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("%s_done_pulses_%0d", name, g), done_cnt[g] - d0[g], 1);
      chk($sformatf("%s_latency_%0d", name, g), done_cyc[g] - fall_cyc,
          (g == 0) ? 269 : (g == 1) ? 268 : 271);
      chk($sformatf("%s_writes_%0d", name, g), wr_cnt[g], 256);
    end
    chk({name, "_busy_end"}, busy_a[0], 0);
    fsync = 1'b1;
    tick(4);
  endtask

  initial begin
    for (int k = 0; k < 256; k++) hist[k] = 32'd0;
    tick(3);
    chk("reset_outputs",
        {enb_a[0], addrb_a[0], wr_en_a[0], wr_addr_a[0], wr_data_a[0], busy_a[0], done_a[0], err_a[0]},
        0);
    rst = 1'b0;
    tick(2);
    fsync = 1'b1;
    tick(5);

    // Uniform histogram
    for (int k = 0; k < 256; k++) hist[k] = 32'd2400;
    build("uniform", 1'b0);
    chk("uniform_lut0",   lut[0][0],   1);
    chk("uniform_lut63",  lut[0][63],  64);
    chk("uniform_lut127", lut[0][127], 127);
    chk("uniform_lut255", lut[0][255], 255);
    chk("uniform_err",    err_a[0],    0);

    // Single level
    for (int k = 0; k < 256; k++) hist[k] = 32'd0;
    hist[100] = 32'd614400;
    build("single", 1'b0);
    chk("single_lut0",   lut[0][0],   0);
    chk("single_lut99",  lut[0][99],  0);
    chk("single_lut100", lut[0][100], 255);
    chk("single_lut255", lut[0][255], 255);
    chk("single_err",    err_a[0],    0);

    // All bins zero
    hist[100] = 32'd0;
    build("zero", 1'b0);
    ok8 = 8'd0;
    for (int k = 0; k < 256; k++) ok8 = ok8 | lut[0][k];
    chk("zero_lut_or", ok8, 0);
    chk("zero_err",    err_a[0], 1);

    // Double count: everything saturates
    hist[0] = 32'd1228800;
    build("double", 1'b0);
    ok8 = 8'hFF;
    for (int k = 0; k < 256; k++) ok8 = ok8 & lut[0][k];
    chk("double_lut_and", ok8, 255);
    chk("double_err",     err_a[0], 5);

    // Extra frame-end edge during a build
    for (int k = 0; k < 256; k++) hist[k] = 32'd2400;
    build("overlap", 1'b1);
    chk("overlap_lut0",   lut[0][0],   1);
    chk("overlap_lut255", lut[0][255], 255);
    chk("overlap_err",    err_a[0],    2);
    build("sticky", 1'b0);
    chk("sticky_err", err_a[0], 2);

    // Reset in the middle of the read phase
    tick(1);
    fsync = 1'b0;
    n = 0;
    while (!(enb_a[0] && addrb_a[0] == 8'd40) && n < 400) begin
      tick(1);
      n++;
    end
    chk("reach_addr40", (n < 400), 1);
    rst = 1'b1;
    #1;
    chk("midreset_outputs",
        {enb_a[0], addrb_a[0], wr_en_a[0], wr_addr_a[0], wr_data_a[0], busy_a[0], done_a[0], err_a[0]},
        0);
    for (int g = 0; g < 3; g++) begin
      d0[g] = done_cnt[g];
      t0[g] = wr_tot[g];
    end
    tick(3);
    rst = 1'b0;
    tick(300);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("midreset_no_done_%0d", g), done_cnt[g] - d0[g], 0);
      chk($sformatf("midreset_no_writes_%0d", g), wr_tot[g] - t0[g], 0);
    end
    fsync = 1'b1;
    tick(4);
    build("postreset", 1'b0);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("offset_bad_%0d", g), offs_bad[g], 0);
      chk($sformatf("sequence_bad_%0d", g), seq_bad[g], 0);
      chk($sformatf("done_while_busy_%0d", g), bsy_bad[g], 0);
      chk($sformatf("postreset_lut127_%0d", g), lut[g][127], 127);
      chk($sformatf("postreset_err_%0d", g), err_a[g], 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
